// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package cache_pkg;

    localparam int CACHE_ADDR_W   = 32;
    localparam int CACHE_SET_BITS = 4;
    localparam int CACHE_OFF_W    = 2;
    localparam int CACHE_IDX_W    = CACHE_SET_BITS;
    localparam int CACHE_TAG_W    = CACHE_ADDR_W - CACHE_SET_BITS - CACHE_OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } cache_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [CACHE_TAG_W-1:0] tag;
    } line_t;

endpackage

// File: rtl/cache_store.sv
// Tag/valid/dirty/data storage: asynchronous read, byte-enabled hit write and
// a separate whole-line fill port. Only valid/dirty are cleared by reset.
module cache_store
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SET_BITS   = CACHE_SET_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SET_BITS-1:0]     rd_idx_i,
    output line_t                   rd_meta_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    input  logic                    wr_en_i,
    input  logic [SET_BITS-1:0]     wr_idx_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    fill_en_i,
    input  logic [SET_BITS-1:0]     fill_idx_i,
    input  logic [CACHE_TAG_W-1:0]  fill_tag_i,
    input  logic [DATA_WIDTH-1:0]   fill_data_i
);

    localparam int NSETS = 2 ** SET_BITS;

    logic [NSETS-1:0]       valid_q;
    logic [NSETS-1:0]       dirty_q;
    logic [CACHE_TAG_W-1:0] tag_q  [NSETS];
    logic [DATA_WIDTH-1:0]  data_q [NSETS];

    // Line state bits; a fill always lands clean
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fill_idx_i] <= 1'b1;
            dirty_q[fill_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data arrays, deliberately without reset
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[fill_idx_i]  <= fill_tag_i;
            data_q[fill_idx_i] <= fill_data_i;
        end else if (wr_en_i) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_be_i[b]) begin
                    data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_meta_o = '{valid: valid_q[rd_idx_i], dirty: dirty_q[rd_idx_i], tag: tag_q[rd_idx_i]};
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: zero-latency hits, and a
// miss FSM that writes back a dirty victim and then refills the line.
module dcache_controller
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = CACHE_ADDR_W,
    parameter int SET_BITS      = CACHE_SET_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_rd,
    input  logic                     cpu_we,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wd,
    input  logic [3:0]               cpu_be,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int TAG_W = ADDRESS_WIDTH - SET_BITS - 2;

    cache_state_t            state_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    logic [SET_BITS-1:0]     idx_s;
    logic [TAG_W-1:0]        tag_s;
    logic [ADDRESS_WIDTH-1:0] fill_addr_s;
    line_t                   meta_s;
    logic [DATA_WIDTH-1:0]   line_data_s;
    logic                    req_s;
    logic                    hit_s;
    logic                    hit_wr_s;
    logic                    fill_s;
    logic                    unused_s;

    assign idx_s       = cpu_addr[SET_BITS+1:2];
    assign tag_s       = cpu_addr[ADDRESS_WIDTH-1:SET_BITS+2];
    assign fill_addr_s = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign unused_s    = ^cpu_addr[1:0];

    assign req_s    = cpu_rd | cpu_we;
    assign hit_s    = meta_s.valid && (meta_s.tag == tag_s);
    assign hit_wr_s = (state_q == IDLE) && cpu_we && hit_s;
    // ALLOCATE always has mem_req high, so any ack here is a real completion
    assign fill_s   = (state_q == ALLOCATE) && mem_ack;

    cache_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .SET_BITS   (SET_BITS)
    ) u_store (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (idx_s),
        .rd_meta_o   (meta_s),
        .rd_data_o   (line_data_s),
        .wr_en_i     (hit_wr_s),
        .wr_idx_i    (idx_s),
        .wr_be_i     (cpu_be),
        .wr_data_i   (cpu_wd),
        .fill_en_i   (fill_s),
        .fill_idx_i  (idx_s),
        .fill_tag_i  (tag_s),
        .fill_data_i (mem_rdata)
    );

    // Miss FSM with registered memory-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s && !hit_s) begin
                        mem_req_q <= 1'b1;
                        if (meta_s.valid && meta_s.dirty) begin
                            state_q     <= WRITEBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {meta_s.tag, idx_s, 2'b00};
                            mem_wdata_q <= line_data_s;
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= fill_addr_s;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        state_q    <= ALLOCATE;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= fill_addr_s;
                    end
                end
                ALLOCATE: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall     = req_s && ((state_q != IDLE) || !hit_s);
    assign cpu_rdata = line_data_s;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus random
// traffic against a word-level cache/memory reference model.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_we;
    logic [31:0] cpu_addr, cpu_wd;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: cache contents per set plus a sparse main memory
    logic [31:0] m_dat [16];
    logic [25:0] m_tag [16];
    bit          m_vld [16];
    bit          m_dty [16];
    logic [31:0] backing [int unsigned];

    dcache_controller #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .SET_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return 32'h5A00_0000 ^ (a * 32'h0001_0003);
    endfunction

    // One pipeline request, served until stall drops; memory acks the
    // wl-th / fl-th cycle of each write-back / refill request.
    task automatic do_req(input logic rd, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          input int wl, input int fl, input string nm,
                          output logic [31:0] got_rdata, output int got_stall);
        logic [3:0]  idx;
        logic [25:0] tg;
        logic [31:0] wa, exp_wb_addr, exp_wb_data, exp_rdata, held_addr;
        logic        hit, exp_wb, held_we;
        int          exp_stall, cyc, scnt, nwb, nfill, rc, lat;
        bit          done;

        idx = a[5:2];
        tg  = a[31:6];
        wa  = {a[31:2], 2'b00};
        hit = m_vld[idx] && (m_tag[idx] == tg);
        exp_wb      = !hit && m_vld[idx] && m_dty[idx];
        exp_wb_addr = {m_tag[idx], idx, 2'b00};
        exp_wb_data = m_dat[idx];
        exp_stall   = hit ? 0 : (1 + (exp_wb ? wl : 0) + fl);
        if (exp_wb) backing[exp_wb_addr] = exp_wb_data;
        if (!hit) begin
            m_dat[idx] = mem_word(wa);
            m_tag[idx] = tg;
            m_vld[idx] = 1'b1;
            m_dty[idx] = 1'b0;
        end
        exp_rdata = m_dat[idx];
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_dat[idx][8*b +: 8] = wd[8*b +: 8];
            m_dty[idx] = 1'b1;
        end

        cpu_rd = rd; cpu_we = we; cpu_addr = a; cpu_wd = wd; cpu_be = be;
        cyc = 0; scnt = 0; nwb = 0; nfill = 0; rc = 0; done = 1'b0;
        held_addr = 32'h0; held_we = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            if (!stall) begin
                done = 1'b1;
            end else begin
                scnt++;
                if (mem_req) begin
                    if (rc == 0) begin
                        held_addr = mem_addr;
                        held_we   = mem_we;
                    end else begin
                        n_cmp++;
                        if (mem_addr !== held_addr || mem_we !== held_we) begin
                            n_fail++;
                            $display("FAIL %s hold: addr/we %h/%b, required %h/%b", nm, mem_addr, mem_we, held_addr, held_we);
                        end
                    end
                    rc++;
                    lat = mem_we ? wl : fl;
                    if (rc >= lat) begin
                        mem_ack = 1'b1;
                        rc = 0;
                        if (mem_we) begin
                            nwb++;
                            n_cmp++;
                            if (mem_addr !== exp_wb_addr || mem_wdata !== exp_wb_data) begin
                                n_fail++;
                                $display("FAIL %s wb: addr/data %h/%h, required %h/%h", nm, mem_addr, mem_wdata, exp_wb_addr, exp_wb_data);
                            end
                        end else begin
                            nfill++;
                            mem_rdata = mem_word(mem_addr);
                            n_cmp++;
                            if (mem_addr !== wa) begin
                                n_fail++;
                                $display("FAIL %s fill_addr: %h, required %h", nm, mem_addr, wa);
                            end
                        end
                    end
                end
                @(negedge clk);
                mem_ack = 1'b0;
                cyc++;
            end
        end
        got_rdata = cpu_rdata;
        got_stall = scnt;
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: stall still high after %0d cycles, required low", nm, cyc);
        end
        n_cmp++;
        if (scnt != exp_stall) begin
            n_fail++;
            $display("FAIL %s stall_cycles: %0d, required %0d", nm, scnt, exp_stall);
        end
        n_cmp++;
        if (nwb != (exp_wb ? 1 : 0) || nfill != (hit ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s txn_count: wb %0d fill %0d, required wb %0d fill %0d", nm, nwb, nfill, exp_wb ? 1 : 0, hit ? 0 : 1);
        end
        n_cmp++;
        if (cpu_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL %s rdata: %h, required %h", nm, cpu_rdata, exp_rdata);
        end
        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_rd = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wd = 32'h0;
        cpu_be = 4'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 16; i++) begin
            m_vld[i] = 1'b0; m_dty[i] = 1'b0; m_tag[i] = 26'h0; m_dat[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({mem_req, mem_we, stall} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: req/we/stall %b%b%b addr %h wdata %h, required all zero", mem_req, mem_we, stall, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_load();
        logic [31:0] rd;
        int          sc;
        backing[32'h100] = 32'hDEADBEEF;
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1, 3, "cold_load", rd, sc);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || sc != 4) begin
            n_fail++;
            $display("FAIL cold_load_const: rdata %h stall %0d, required DEADBEEF 4", rd, sc);
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd;
        int          sc;
        do_req(1'b0, 1'b1, 32'h100, 32'h0000AB00, 4'b0010, 1, 1, "store_hit", rd, sc);
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1, 1, "load_after_store", rd, sc);
        n_cmp++;
        if (rd !== 32'hDEADABEF || sc != 0) begin
            n_fail++;
            $display("FAIL store_merge: rdata %h stall %0d, required DEADABEF 0", rd, sc);
        end
    endtask

    task automatic test_evictions();
        logic [31:0] rd;
        int          sc;
        do_req(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, 2, 2, "dirty_evict", rd, sc);
        n_cmp++;
        if (backing[32'h100] !== 32'hDEADABEF || sc != 5) begin
            n_fail++;
            $display("FAIL dirty_evict_const: victim %h stall %0d, required DEADABEF 5", backing[32'h100], sc);
        end
        do_req(1'b1, 1'b0, 32'h180, 32'h0, 4'h0, 1, 2, "clean_evict", rd, sc);
        do_req(1'b1, 1'b0, 32'h1C0, 32'h0, 4'h0, 1, 10, "handshake_hold", rd, sc);
        n_cmp++;
        if (sc != 11) begin
            n_fail++;
            $display("FAIL handshake_hold_stall: %0d, required 11", sc);
        end
    endtask

    task automatic test_spurious_ack();
        logic [31:0] rd;
        int          sc;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL spurious_ack: req %b stall %b, required 0 0", mem_req, stall);
        end
        @(negedge clk);
        do_req(1'b1, 1'b0, 32'h1C0, 32'h0, 4'h0, 1, 1, "after_spurious", rd, sc);
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd;
        int          sc;
        cpu_rd = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL midfill_req: req/we %b%b, required 10", mem_req, mem_we);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_req: %b, required 0", mem_req);
        end
        @(negedge clk);
        rst = 1'b0; cpu_rd = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_vld[i] = 1'b0; m_dty[i] = 1'b0;
        end
        @(negedge clk);
        do_req(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1, 2, "reload_after_reset", rd, sc);
        n_cmp++;
        if (sc != 3) begin
            n_fail++;
            $display("FAIL reload_miss: stall %0d, required 3", sc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, a;
        logic        r, w;
        int          sc;
        for (int i = 0; i < 80; i++) begin
            a = 32'h0000_1000 | (32'($urandom_range(0, 3)) << 6)
                | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            do_req(r, w, a, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(1, 4), $urandom_range(1, 4), "random", rd, sc);
        end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_evictions();
        test_spurious_ack();
        test_reset_mid_refill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
